// File: rtl/rv32i_pkg.sv
// Shared RV32I encodings, ALU operation enum and execute-stage register layout.
// Imported by the execute stage and its ALU.
package rv32i_pkg;

   localparam logic [4:0] OP     = 5'b01100;
   localparam logic [4:0] OP_IMM = 5'b00100;
   localparam logic [4:0] LUI    = 5'b01101;
   localparam logic [4:0] AUIPC  = 5'b00101;
   localparam logic [4:0] JAL    = 5'b11011;
   localparam logic [4:0] JALR   = 5'b11001;
   localparam logic [4:0] BRANCH = 5'b11000;
   localparam logic [4:0] LOAD   = 5'b00000;
   localparam logic [4:0] STORE  = 5'b01000;
   localparam logic [4:0] SYSTEM = 5'b11100;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   // CSR ops are identified by funct3[1:0]; funct3[2] selects the zimm operand
   localparam logic [1:0] F3_CSRRW = 2'b01;
   localparam logic [1:0] F3_CSRRS = 2'b10;
   localparam logic [1:0] F3_CSRRC = 2'b11;

   localparam logic [31:0] NOP_INSTR    = 32'h0000_0033;
   localparam int          SQUASH_DEPTH = 2;

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
      ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
   } alu_op_e;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] alu;
      logic [31:0] store_data;
      logic [31:0] csr_data;
      logic [31:0] pc_p4;
      logic [4:0]  rd;
      logic [5:0]  csr_addr;
      logic        reg_write;
      logic        csr_write;
      logic        mem_read;
      logic        mem_write;
   } ex_mem_t;

endpackage

// File: rtl/stage3_if.sv
// Execute-stage bus: decode-side inputs, forwarding/redirect outputs and
// the registered execute/memory pipeline register.
interface stage3_if;
   logic        halt;
   logic [31:0] instr_i, rdata_i, rdata1_i, rdata2_i, pc_i, pcP4_i;
   logic        redirect_o;
   logic [31:0] target_o, fwd_data_o, fwd_csrData_o;
   logic [4:0]  fwd_rd_o;
   logic [5:0]  fwd_csrAddr_o;
   logic        fwd_regWrite_o, fwd_csrWrite_o, load_pending_o;
   logic [31:0] instr_o, alu_o, storeData_o, csrData_o, pcP4_o;
   logic [4:0]  rd_o;
   logic [5:0]  csrAddr_o;
   logic        regWrite_o, csrWrite_o, memRead_o, memWrite_o;

   modport master (
      output halt, instr_i, rdata_i, rdata1_i, rdata2_i, pc_i, pcP4_i,
      input  redirect_o, target_o, fwd_data_o, fwd_rd_o, fwd_regWrite_o,
             fwd_csrData_o, fwd_csrAddr_o, fwd_csrWrite_o, load_pending_o,
             instr_o, alu_o, storeData_o, csrData_o, pcP4_o, rd_o, csrAddr_o,
             regWrite_o, csrWrite_o, memRead_o, memWrite_o
   );

   modport slave (
      input  halt, instr_i, rdata_i, rdata1_i, rdata2_i, pc_i, pcP4_i,
      output redirect_o, target_o, fwd_data_o, fwd_rd_o, fwd_regWrite_o,
             fwd_csrData_o, fwd_csrAddr_o, fwd_csrWrite_o, load_pending_o,
             instr_o, alu_o, storeData_o, csrData_o, pcP4_o, rd_o, csrAddr_o,
             regWrite_o, csrWrite_o, memRead_o, memWrite_o
   );
endinterface

// File: rtl/stage3_alu.sv
// RV32I integer ALU: 32-bit modulo arithmetic, logic, shifts and compares.
module alu
   import rv32i_pkg::*;
(
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  alu_op_e     op,
   output logic [31:0] y
);
   always_comb begin
      y = '0;
      unique case (op)
         ALU_ADD:  y = a + b;
         ALU_SUB:  y = a - b;
         ALU_SLL:  y = a << b[4:0];
         ALU_SLT:  y = {31'b0, $signed(a) < $signed(b)};
         ALU_SLTU: y = {31'b0, a < b};
         ALU_XOR:  y = a ^ b;
         ALU_SRL:  y = a >> b[4:0];
         ALU_SRA:  y = $unsigned($signed(a) >>> b[4:0]);
         ALU_OR:   y = a | b;
         ALU_AND:  y = a & b;
         default:  y = a + b;
      endcase
   end
endmodule

// File: rtl/stage3.sv
// RV32I execute stage: ALU/branch/jump/CSR results, redirect to fetch,
// wrong-path squash and the execute/memory pipeline register.
module stage3
   import rv32i_pkg::*;
(
   input logic     clk,
   input logic     reset,
   stage3_if.slave bus
);
   localparam int SQW = $clog2(SQUASH_DEPTH + 1);

   logic [31:0] instr, rs1, rs2, old_csr, pc, pc_p4;
   assign instr   = bus.instr_i;
   assign rs1     = bus.rdata1_i;
   assign rs2     = bus.rdata2_i;
   assign old_csr = bus.rdata_i;
   assign pc      = bus.pc_i;
   assign pc_p4   = bus.pcP4_i;

   logic [4:0]  opc, rd;
   logic [2:0]  f3;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   assign opc   = instr[6:2];
   assign f3    = instr[14:12];
   assign rd    = instr[11:7];
   assign imm_i = {{20{instr[31]}}, instr[31:20]};
   assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
   assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   assign imm_u = {instr[31:12], 12'b0};
   assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

   alu_op_e     op;
   logic [31:0] a, b, alu_y, csr_opnd, csr_new, res, target;
   logic        reg_wr, csr_wr, is_load, is_store, is_csr, jump, take;

   alu u_alu (.a(a), .b(b), .op(op), .y(alu_y));

   always_comb begin
      op       = ALU_ADD;
      a        = rs1;
      b        = imm_i;
      reg_wr   = 1'b0;
      csr_wr   = 1'b0;
      is_load  = 1'b0;
      is_store = 1'b0;
      is_csr   = 1'b0;
      jump     = 1'b0;
      take     = 1'b0;
      csr_opnd = f3[2] ? {27'b0, instr[19:15]} : rs1;
      csr_new  = old_csr;
      case (opc)
         OP, OP_IMM: begin
            reg_wr = 1'b1;
            b      = (opc == OP) ? rs2 : imm_i;
            case (f3)
               F3_ADD:  op = (opc == OP && instr[30]) ? ALU_SUB : ALU_ADD;
               F3_SLL:  op = ALU_SLL;
               F3_SLT:  op = ALU_SLT;
               F3_SLTU: op = ALU_SLTU;
               F3_XOR:  op = ALU_XOR;
               F3_SR:   op = instr[30] ? ALU_SRA : ALU_SRL;
               F3_OR:   op = ALU_OR;
               default: op = ALU_AND;
            endcase
         end
         LUI:   begin a = '0; b = imm_u; reg_wr = 1'b1; end
         AUIPC: begin a = pc; b = imm_u; reg_wr = 1'b1; end
         JAL, JALR: begin jump = 1'b1; reg_wr = 1'b1; end
         BRANCH: begin
            case (f3)
               F3_BEQ:  take = (rs1 == rs2);
               F3_BNE:  take = (rs1 != rs2);
               F3_BLT:  take = ($signed(rs1) <  $signed(rs2));
               F3_BGE:  take = ($signed(rs1) >= $signed(rs2));
               F3_BLTU: take = (rs1 <  rs2);
               F3_BGEU: take = (rs1 >= rs2);
               default: take = 1'b0;
            endcase
         end
         LOAD:  begin is_load = 1'b1; reg_wr = 1'b1; end
         STORE: begin is_store = 1'b1; b = imm_s; end
         SYSTEM: begin
            // funct3 of 000/100 is not a CSR access and falls through as a NOP
            if (f3[1:0] != 2'b00) begin
               is_csr = 1'b1;
               reg_wr = 1'b1;
               case (f3[1:0])
                  F3_CSRRW: begin csr_new = csr_opnd;            csr_wr = 1'b1; end
                  F3_CSRRS: begin csr_new = old_csr | csr_opnd;  csr_wr = (instr[19:15] != 5'd0); end
                  default:  begin csr_new = old_csr & ~csr_opnd; csr_wr = (instr[19:15] != 5'd0); end
               endcase
            end
         end
         default: ;
      endcase
   end

   assign target = (opc == JALR) ? ((rs1 + imm_i) & ~32'd1)
                                 : (pc + ((opc == JAL) ? imm_j : imm_b));
   assign res    = jump ? pc_p4 : (is_csr ? old_csr : alu_y);

   logic [SQW-1:0] sq;
   logic           live, redirect, wr_en;
   assign live     = (sq == '0);
   assign redirect = live && (jump || take);
   assign wr_en    = reg_wr && (rd != 5'd0);

   assign bus.redirect_o     = redirect;
   assign bus.target_o       = target;
   assign bus.fwd_data_o     = res;
   assign bus.fwd_rd_o       = rd;
   assign bus.fwd_regWrite_o = live && wr_en && !is_load;
   assign bus.fwd_csrData_o  = csr_new;
   assign bus.fwd_csrAddr_o  = instr[25:20];
   assign bus.fwd_csrWrite_o = live && csr_wr;
   assign bus.load_pending_o = live && is_load;

   ex_mem_t q;

   always_ff @(posedge clk) begin
      if (reset) begin
         q       <= '0;
         q.instr <= NOP_INSTR;
         sq      <= '0;
      end else if (!bus.halt) begin
         if (!live) begin
            q       <= '0;
            q.instr <= NOP_INSTR;
            sq      <= sq - SQW'(1);
         end else begin
            q.instr      <= instr;
            q.alu        <= res;
            q.store_data <= rs2;
            q.csr_data   <= csr_new;
            q.pc_p4      <= pc_p4;
            q.rd         <= rd;
            q.csr_addr   <= instr[25:20];
            q.reg_write  <= wr_en;
            q.csr_write  <= csr_wr;
            q.mem_read   <= is_load;
            q.mem_write  <= is_store;
            if (redirect) sq <= SQW'(SQUASH_DEPTH);
         end
      end
   end

   assign bus.instr_o     = q.instr;
   assign bus.alu_o       = q.alu;
   assign bus.storeData_o = q.store_data;
   assign bus.csrData_o   = q.csr_data;
   assign bus.pcP4_o      = q.pc_p4;
   assign bus.rd_o        = q.rd;
   assign bus.csrAddr_o   = q.csr_addr;
   assign bus.regWrite_o  = q.reg_write;
   assign bus.csrWrite_o  = q.csr_write;
   assign bus.memRead_o   = q.mem_read;
   assign bus.memWrite_o  = q.mem_write;
endmodule

// File: doc/stage3.md
Name: stage3

Overview:
Execute stage of the 5-stage RV32I pipeline, directly downstream of the decode/register-read stage.
- Consumes the decoded instruction, forwarded rs1/rs2/CSR operands, pc and pc+4.
- Computes the ALU, branch, jump and CSR results, and resolves control flow with a redirect to fetch.
- Squashes the two wrong-path instructions behind a taken branch or jump.
- Registers results into the memory stage and presents same-cycle forwarding data back to decode.

Parameters:
NOP_INSTR, 32'h00000033, bubble encoding (add x0,x0,x0)
SQUASH_DEPTH, 2, younger instructions killed after a redirect

Ports:
clk  in  1  clock
reset  in  1  reset
halt  in  1  freeze all state (pipeline stall)
instr_i  in  32  instruction from decode
rdata_i  in  32  forwarded CSR old value
rdata1_i  in  32  forwarded rs1 value
rdata2_i  in  32  forwarded rs2 value
pc_i  in  32  instruction pc
pcP4_i  in  32  pc+4
redirect_o  out  1  taken branch/jump, combinational
target_o  out  32  redirect target, combinational
fwd_data_o  out  32  execute result of current instruction, combinational
fwd_rd_o  out  5  rd of current instruction
fwd_regWrite_o  out  1  current instruction writes rd (0 if squashed, load, or rd==0)
fwd_csrData_o  out  32  new CSR value
fwd_csrAddr_o  out  6  CSR address instr[25:20]
fwd_csrWrite_o  out  1  current instruction writes the CSR
load_pending_o  out  1  current instruction is a live load (hazard unit stalls)
instr_o  out  32  registered instruction
alu_o  out  32  registered result or memory address
storeData_o  out  32  registered rs2
csrData_o  out  32  registered new CSR value
pcP4_o  out  32  registered pc+4
rd_o  out  5  registered rd
csrAddr_o  out  6  registered CSR address
regWrite_o  out  1  registered write enable
csrWrite_o  out  1  registered CSR write enable
memRead_o  out  1  registered load
memWrite_o  out  1  registered store

Behaviour:
Reset and clocking:
- Reset is synchronous, active-high, on clock clk.
- On reset: instr_o=NOP_INSTR; all enables (regWrite_o, csrWrite_o, memRead_o, memWrite_o) =0; rd_o=0, csrAddr_o=0, alu_o=0, storeData_o=0, csrData_o=0, pcP4_o=0; squash counter=0.

Decode and results (opcode = instr_i[6:2]):
- OP 01100 and OP-IMM 00100: full RV32I ALU.
  - funct3/funct7[5] select the operation; SUB/SRA apply only to OP; SRAI uses instr[30].
  - Shift amount is bits [4:0] of the operand.
  - SLT is signed, SLTU unsigned.
- LUI 01101: result = U-immediate. AUIPC 00101: result = pc + U-immediate.
- JAL 11011: target = pc + J-immediate. JALR 11001: target = (rs1 + I-immediate) with bit 0 cleared. For both, result = pcP4 and redirect=1.
- BRANCH 11000: compare using BEQ/BNE/BLT/BGE/BLTU/BGEU; if taken, target = pc + B-immediate and redirect=1; regWrite=0.
- LOAD 00000: alu = rs1 + I-immediate; memRead=1; regWrite=1 in the registered output only.
- STORE 01000: alu = rs1 + S-immediate; memWrite=1; storeData = rs2.
- SYSTEM 11100, funct3 != 0 (CSR access):
  - rd result = rdata_i (old CSR value).
  - Operand = rs1 for funct3[2]=0, or zero-extended zimm instr[19:15] for funct3[2]=1.
  - New value: RW → operand; RS → old|operand; RC → old & ~operand.
  - csrWrite=1, except RS/RC with instr[19:15]==0 (no write).
- Any other opcode: treated as NOP, with no enables asserted.
- Arithmetic is 32-bit modulo; carries are dropped.
- regWrite is forced to 0 when rd==0.

Squash control:
- A counter sq in 0..SQUASH_DEPTH.
- An instruction is live iff sq==0.
- A live redirect on a non-halt cycle loads sq=SQUASH_DEPTH.
- While sq>0, on each non-halt cycle: decrement sq and latch NOP_INSTR with all enables 0.
- Squashed instructions never assert redirect_o or any fwd_* enable.
- A branch that arrives while squashed is ignored.

Halt:
- Output registers and sq hold their values.
- redirect_o is still computed combinationally, but sq is not loaded until the first non-halt cycle.
- Fetch must not act on the redirect while halted.

Latency and simultaneous events:
- Latency is 1 cycle from inputs to registered outputs.
- reset dominates halt, and halt dominates update.
- Reset during a squash clears sq to 0.

Decomposition:
Shared package rv32i_pkg holds:
- The opcode constants (OP, OP_IMM, LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, SYSTEM).
- The funct3 ALU/branch/CSR constants, NOP_INSTR, and an alu_op_e enum.

Sub-module alu (operands a and b, alu_op_e op, 32-bit result), instantiated once; the branch comparator stays inline.

Test Plan:
- Reset, then release with halt=0 and a NOP input → instr_o=32'h00000033, all enables 0, redirect_o=0.
- add x3,x1,x2 with rdata1=5 and rdata2=7 → fwd_data_o=12 and fwd_rd_o=3 the same cycle; next cycle alu_o=12, regWrite_o=1.
- beq taken (rs1=rs2=9, pc=0x100, offset +16) → redirect_o=1, target_o=0x110; the next two inputs latch as NOP with enables 0; the third input passes through.
- jalr x1 with rs1=0x203 and imm=0 → target_o=0x202 and alu_o=pcP4_i; a branch inside the squash window produces no redirect.
- csrrs with rs1 field 0 and rdata_i=0xA5 → rd result 0xA5, csrWrite=0; csrrc with rs1=0x0F and old value 0xFF → csrData_o=0xF0, csrWrite_o=1.
- Taken branch followed by halt=1 for 3 cycles → outputs and sq frozen; after release, exactly two squashed slots follow. Reset asserted mid-squash → sq=0 and the next live instruction is not squashed.
